// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared FSM encoding and default sizing for the register write arbiter
package reg_write_arbiter_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/en_reg.sv
// rtl/en_reg.sv - W-bit storage register with synchronous reset and load enable
module en_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter serialising N requesters onto one shared register
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       data_in,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic [W-1:0]         q,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);

    localparam int PW = $clog2(N);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] pick;
    logic [PW-1:0] cand;
    logic          found;
    logic          q_en;
    logic [W-1:0]  slice [N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign slice[i] = data_in[i*W +: W];
    end

    // Search starts just after the last winner, so the last winner ranks lowest.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int off = 1; off <= N; off++) begin
            cand = PW'((int'(ptr) + off) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign q_en = (state == GRANT);
    assign busy = (state != IDLE);

    en_reg #(.W(W)) u_q (
        .clk   (clk),
        .reset (reset),
        .en    (q_en),
        .d     (slice[win]),
        .q     (q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= '0;
            owner <= '0;
            win   <= '0;
            ptr   <= PW'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    gnt <= '0;
                    if (found) begin
                        win   <= pick;
                        gnt   <= {{(N-1){1'b0}}, 1'b1} << pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    gnt   <= '0;
                    ack   <= {{(N-1){1'b0}}, 1'b1} << win;
                    owner <= win;
                    state <= DONE;
                end
                DONE: begin
                    ack   <= '0;
                    ptr   <= win;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter
module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           busy;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    reg_write_arbiter #(.N(N), .W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .ack     (ack),
        .q       (q),
        .owner   (owner),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        data_in = {d3, d2, d1, d0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every ack must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && ((|gnt) || (|ack))) begin
            check("gnt_ack_excl", 32'((|gnt) && (|ack)), 32'd0);
        end
        if (!reset && ack != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_onehot", 32'(ack), 32'(1 << e.idx));
                check("q_data", 32'(q), 32'(e.data));
                check("owner", 32'(owner), 32'(e.idx));
            end
        end
    end

    initial begin
        int last_ack;
        int waited;
        reset = 1'b1;
        req   = '0;
        set_data(8'h00, 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_q", 32'(q), 32'h00);
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_ack", 32'(ack), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_owner", 32'(owner), 32'h0);
        end
        reset = 1'b0;
        step();

        // Single write from requester 2.
        set_data(8'h00, 8'h00, 8'hA5, 8'h00);
        req = 4'b0100;
        exp_q.push_back('{2, 8'hA5});
        step();
        check("s_gnt", 32'(gnt), 32'b0100);
        check("s_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        step();
        check("s_q", 32'(q), 32'hA5);
        check("s_owner", 32'(owner), 32'd2);
        check("s_ack", 32'(ack), 32'b0100);
        check("s_gnt_off", 32'(gnt), 32'h0);
        step();
        check("s_ack_off", 32'(ack), 32'h0);
        check("s_busy_off", 32'(busy), 32'h0);
        step();

        // All four requesting after reset: order 0,1,2,3,0 every 3 cycles.
        reset = 1'b1;
        req   = 4'b1111;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        step();
        step();
        check("rr_rst_q", 32'(q), 32'h00);
        for (int i = 0; i < 5; i++) exp_q.push_back('{i % 4, 8'(8'h10 + (i % 4))});
        reset = 1'b0;
        last_ack = 0;
        for (int i = 0; i < 5; i++) begin
            waited = 0;
            step();
            while (ack == '0 && waited < 20) begin
                step();
                waited++;
            end
            if (waited >= 20) begin
                check("rr_timeout", 32'(waited), 32'd0);
                break;
            end
            if (i > 0) check("rr_spacing", 32'(cyc - last_ack), 32'd3);
            last_ack = cyc;
        end
        req = 4'b0000;
        step();
        step();
        check("rr_idle", 32'(busy), 32'h0);

        // Requester 0 pulses for one cycle and drops during GRANT.
        set_data(8'h3C, 8'h00, 8'h00, 8'h00);
        req = 4'b0001;
        exp_q.push_back('{0, 8'h3C});
        step();
        check("p_gnt", 32'(gnt), 32'b0001);
        req = 4'b0000;
        step();
        check("p_ack", 32'(ack), 32'b0001);
        check("p_q", 32'(q), 32'h3C);
        step();
        step();

        // Reset during GRANT aborts the write of 0x77 by requester 1.
        set_data(8'h5A, 8'h77, 8'h00, 8'h00);
        req = 4'b0010;
        step();
        check("a_gnt", 32'(gnt), 32'b0010);
        reset = 1'b1;
        req   = 4'b0011;
        step();
        check("a_q", 32'(q), 32'h00);
        check("a_ack", 32'(ack), 32'h0);
        check("a_gnt_off", 32'(gnt), 32'h0);
        check("a_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        exp_q.push_back('{0, 8'h5A});
        step();
        check("a_first_gnt", 32'(gnt), 32'b0001);
        req = 4'b0000;
        step();
        step();
        step();

        // Request change during GRANT does not move the winner.
        set_data(8'h20, 8'h21, 8'h22, 8'h23);
        req = 4'b1010;
        exp_q.push_back('{1, 8'h21});
        exp_q.push_back('{2, 8'h22});
        step();
        check("c_gnt1", 32'(gnt), 32'b0010);
        req = 4'b0101;
        step();
        check("c_ack1", 32'(ack), 32'b0010);
        step();
        step();
        check("c_gnt2", 32'(gnt), 32'b0100);
        req = 4'b0000;
        step();
        check("c_q2", 32'(q), 32'h22);
        step();
        step();
        step();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
